// File: rtl/clause_dist_buffer_pkg.sv
// Shared solver types for the clause distribution path: clause node and dummy-pointer formats,
// plus the default engine count used by the loaders.
package clause_dist_buffer_pkg;

  localparam int unsigned NODE_W             = 16;
  localparam int unsigned PTR_W              = 12;
  localparam int unsigned NUM_ENGINE_DEFAULT = 4;

  typedef logic [NODE_W-1:0] node_t;
  typedef logic [PTR_W-1:0]  ptr_t;

  // Engine index width, never narrower than one bit so a single-engine build still has a port.
  function automatic int unsigned eng_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clause_dist_buffer_sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module sync_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    empty_o = (wr_q == rd_q);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
    rdata_o = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents as valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/clause_dist_buffer.sv
// Distributes an incoming clause stream over NUM_ENGINE per-engine FIFOs, advancing the target
// engine manually (change_eng) or automatically after a programmable clause quota.
module clause_dist_buffer
  import clause_dist_buffer_pkg::*;
#(
  parameter int unsigned  NUM_ENGINE = NUM_ENGINE_DEFAULT,
  parameter int unsigned  FIFO_DEPTH = 4,
  parameter int unsigned  QUOTA_W    = 8,
  localparam int unsigned ENG_W      = eng_width(NUM_ENGINE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [QUOTA_W-1:0]    quota,
  input  node_t                 node_in,
  input  logic                  node_in_valid,
  output logic                  node_in_ready,
  input  ptr_t                  ptr_in,
  input  logic                  ptr_in_valid,
  input  logic                  change_eng,
  output node_t                 clause_out [NUM_ENGINE],
  output logic [NUM_ENGINE-1:0] clause_valid_out,
  input  logic [NUM_ENGINE-1:0] clause_ready_in,
  output ptr_t                  ptr_out [NUM_ENGINE],
  output logic [NUM_ENGINE-1:0] ptr_valid_out,
  output logic [ENG_W-1:0]      cur_eng,
  output logic                  all_loaded
);

  localparam logic [ENG_W-1:0] LastEng = ENG_W'(NUM_ENGINE - 1);

  logic [NUM_ENGINE-1:0] push, pop, full, empty, ptr_wr;
  logic                  node_accept;

  logic [ENG_W-1:0]   cur_eng_q, cur_eng_d;
  logic               all_loaded_q, all_loaded_d;
  logic [QUOTA_W-1:0] cnt_q, cnt_d, cnt_base, quota_eff;
  logic [QUOTA_W:0]   cnt_inc;
  logic               mode_q;
  logic               auto_hit, advance;

  ptr_t                  ptr_q [NUM_ENGINE];
  logic [NUM_ENGINE-1:0] ptr_valid_q;

  // Ready is a function of state only so the loader may wait on it before asserting valid.
  assign node_in_ready = ~full[cur_eng_q];
  assign node_accept   = node_in_valid & node_in_ready;

  for (genvar g = 0; g < NUM_ENGINE; g++) begin : g_eng
    assign push[g]             = node_accept && (cur_eng_q == ENG_W'(g));
    assign ptr_wr[g]           = ptr_in_valid && (cur_eng_q == ENG_W'(g));
    assign pop[g]              = ~empty[g] & clause_ready_in[g];
    assign clause_valid_out[g] = ~empty[g];

    sync_fifo #(
      .Width (NODE_W),
      .Depth (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[g]),
      .wdata_i (node_in),
      .pop_i   (pop[g]),
      .rdata_o (clause_out[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end

  always_comb begin
    quota_eff    = (quota == '0) ? QUOTA_W'(1) : quota;
    // A mode flip restarts the quota count for the engine being loaded.
    cnt_base     = (mode != mode_q) ? '0 : cnt_q;
    cnt_inc      = {1'b0, cnt_base} + (QUOTA_W + 1)'(1);
    auto_hit     = mode && node_accept && (cnt_inc == {1'b0, quota_eff});
    advance      = auto_hit || (!mode && change_eng);

    cnt_d        = cnt_base;
    cur_eng_d    = cur_eng_q;
    all_loaded_d = all_loaded_q;

    if (mode && node_accept) begin
      cnt_d = cnt_inc[QUOTA_W-1:0];
    end
    if (auto_hit) begin
      cnt_d = '0;
    end
    if (advance) begin
      if (cur_eng_q == LastEng) begin
        cur_eng_d    = '0;
        all_loaded_d = 1'b1;
      end else begin
        cur_eng_d = cur_eng_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_eng_q    <= '0;
      all_loaded_q <= 1'b0;
      cnt_q        <= '0;
      mode_q       <= 1'b0;
    end else begin
      cur_eng_q    <= cur_eng_d;
      all_loaded_q <= all_loaded_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENGINE; i++) begin
        ptr_q[i] <= '0;
      end
      ptr_valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENGINE; i++) begin
        if (ptr_wr[i]) begin
          ptr_q[i] <= ptr_in;
        end
      end
      ptr_valid_q <= ptr_wr;
    end
  end

  assign ptr_out       = ptr_q;
  assign ptr_valid_out = ptr_valid_q;
  assign cur_eng       = cur_eng_q;
  assign all_loaded    = all_loaded_q;

endmodule

// File: tb/tb_clause_dist_buffer.sv
// Directed bench for clause_dist_buffer: expected clauses are queued per engine as they are
// offered and a monitor compares every FIFO pop against the head of that engine's queue.
module tb_clause_dist_buffer;
  import clause_dist_buffer_pkg::*;

  localparam int NE = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mode = 1'b0;
  logic [7:0]      quota = '0;
  node_t           node_in = '0;
  logic            node_in_valid = 1'b0;
  logic            node_in_ready;
  ptr_t            ptr_in = '0;
  logic            ptr_in_valid = 1'b0;
  logic            change_eng = 1'b0;
  node_t           clause_out [NE];
  logic [NE-1:0]   clause_valid_out;
  logic [NE-1:0]   clause_ready_in = '0;
  ptr_t            ptr_out [NE];
  logic [NE-1:0]   ptr_valid_out;
  logic [1:0]      cur_eng;
  logic            all_loaded;

  int    n_cmp = 0;
  int    n_err = 0;
  node_t exp_q [NE][$];

  clause_dist_buffer #(
    .NUM_ENGINE (NE),
    .FIFO_DEPTH (4),
    .QUOTA_W    (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mode             (mode),
    .quota            (quota),
    .node_in          (node_in),
    .node_in_valid    (node_in_valid),
    .node_in_ready    (node_in_ready),
    .ptr_in           (ptr_in),
    .ptr_in_valid     (ptr_in_valid),
    .change_eng       (change_eng),
    .clause_out       (clause_out),
    .clause_valid_out (clause_valid_out),
    .clause_ready_in  (clause_ready_in),
    .ptr_out          (ptr_out),
    .ptr_valid_out    (ptr_valid_out),
    .cur_eng          (cur_eng),
    .all_loaded       (all_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake on an engine output must match that engine's next expected clause.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NE; i++) begin
        if (clause_valid_out[i] && clause_ready_in[i]) begin
          if (exp_q[i].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_eng%0d: got %0h, expected no clause", i, clause_out[i]);
          end else begin
            chk($sformatf("pop_eng%0d", i), 32'(clause_out[i]), 32'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NE; i++) s += exp_q[i].size();
    return s;
  endfunction

  // One cycle of stimulus; an offered node is expected at engine eng iff exp_rdy.
  task automatic step(input bit nv, input node_t n, input bit pv, input ptr_t p, input bit ch,
                      input bit exp_rdy, input int eng);
    node_in_valid = nv;
    node_in       = n;
    ptr_in_valid  = pv;
    ptr_in        = p;
    change_eng    = ch;
    @(negedge clk);
    if (nv) begin
      chk("node_in_ready", 32'(node_in_ready), 32'(exp_rdy));
      if (exp_rdy) exp_q[eng].push_back(n);
    end
    @(posedge clk);
    #1;
    node_in_valid = 1'b0;
    ptr_in_valid  = 1'b0;
    change_eng    = 1'b0;
  endtask

  task automatic push(input node_t n, input int eng);
    step(1'b1, n, 1'b0, '0, 1'b0, 1'b1, eng);
  endtask

  task automatic adv();
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 0);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    clause_ready_in = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NE; i++) exp_q[i].delete();
  endtask

  task automatic drain();
    clause_ready_in = '1;
    for (int c = 0; c < 20 && pending() != 0; c++) idle(1);
    if (pending() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d clauses outstanding, expected 0", pending());
    end
    @(negedge clk);
    chk("drained_valid", 32'(clause_valid_out), 32'h0);
    clause_ready_in = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    idle(1);
    do_reset();

    // Reset state
    chk("rst_valid", 32'(clause_valid_out), 32'h0);
    chk("rst_cur_eng", 32'(cur_eng), 32'h0);
    chk("rst_all_loaded", 32'(all_loaded), 32'h0);
    chk("rst_ready", 32'(node_in_ready), 32'h1);
    chk("rst_ptr_valid", 32'(ptr_valid_out), 32'h0);
    for (int i = 0; i < NE; i++) chk($sformatf("rst_ptr%0d", i), 32'(ptr_out[i]), 32'h0);

    // Manual: 3 nodes to engine 0, advance, 2 nodes to engine 1
    mode = 1'b0;
    push(16'h1001, 0);
    push(16'h1002, 0);
    push(16'h1003, 0);
    adv();
    push(16'h1101, 1);
    push(16'h1102, 1);
    chk("man_cur_eng", 32'(cur_eng), 32'h1);
    chk("man_valid", 32'(clause_valid_out), 32'h3);
    chk("man_all_loaded", 32'(all_loaded), 32'h0);
    drain();

    // Auto, quota 2: eight nodes back-to-back, two per engine
    do_reset();
    mode  = 1'b1;
    quota = 8'd2;
    for (int k = 0; k < 8; k++) begin
      push(node_t'(16'h2000 + k), k / 2);
      if (k == 1) chk("auto_cur_eng_k1", 32'(cur_eng), 32'h1);
      if (k == 6) chk("auto_all_loaded_k6", 32'(all_loaded), 32'h0);
    end
    chk("auto_all_loaded", 32'(all_loaded), 32'h1);
    chk("auto_cur_eng", 32'(cur_eng), 32'h0);
    drain();

    // Auto: change_eng ignored, mode toggle restarts the count
    do_reset();
    mode  = 1'b1;
    quota = 8'd3;
    push(16'h2501, 0);
    adv();
    chk("auto_chg_ignored", 32'(cur_eng), 32'h0);
    mode = 1'b0;
    idle(1);
    mode = 1'b1;
    push(16'h2502, 0);
    push(16'h2503, 0);
    chk("mode_clr_no_adv", 32'(cur_eng), 32'h0);
    push(16'h2504, 0);
    chk("mode_clr_adv", 32'(cur_eng), 32'h1);
    drain();

    // Backpressure: FIFO0 fills at 4, fifth accepted the cycle after one pop
    do_reset();
    mode = 1'b0;
    for (int k = 0; k < 4; k++) push(node_t'(16'h3000 + k), 0);
    step(1'b1, 16'h3004, 1'b0, '0, 1'b0, 1'b0, 0);
    clause_ready_in = 4'b0001;
    step(1'b1, 16'h3004, 1'b0, '0, 1'b0, 1'b0, 0);
    clause_ready_in = 4'b0000;
    step(1'b1, 16'h3004, 1'b0, '0, 1'b0, 1'b1, 0);
    chk("bp_full_again", 32'(node_in_ready), 32'h0);
    drain();

    // Simultaneous node + pointer + change_eng on engine 2
    do_reset();
    mode = 1'b0;
    adv();
    adv();
    step(1'b1, 16'h4242, 1'b1, 12'h05A, 1'b1, 1'b1, 2);
    chk("sim_ptr_valid", 32'(ptr_valid_out), 32'h4);
    chk("sim_ptr2", 32'(ptr_out[2]), 32'h05A);
    chk("sim_cur_eng", 32'(cur_eng), 32'h3);
    chk("sim_valid", 32'(clause_valid_out), 32'h4);
    idle(1);
    chk("sim_ptr_strobe_end", 32'(ptr_valid_out), 32'h0);
    chk("sim_ptr2_held", 32'(ptr_out[2]), 32'h05A);
    chk("sim_ptr3", 32'(ptr_out[3]), 32'h0);
    chk("sim_ptr0", 32'(ptr_out[0]), 32'h0);
    drain();

    // Quota 0 behaves as 1: advance after every node
    do_reset();
    mode  = 1'b1;
    quota = 8'd0;
    push(16'h5000, 0);
    push(16'h5001, 1);
    push(16'h5002, 2);
    push(16'h5003, 3);
    push(16'h5004, 0);
    chk("q0_cur_eng", 32'(cur_eng), 32'h1);
    chk("q0_all_loaded", 32'(all_loaded), 32'h1);
    drain();

    // Reset mid-load discards buffered clauses and the sticky flag
    do_reset();
    mode = 1'b0;
    repeat (4) adv();
    chk("wrap_all_loaded", 32'(all_loaded), 32'h1);
    chk("wrap_cur_eng", 32'(cur_eng), 32'h0);
    push(16'h6000, 0);
    push(16'h6001, 0);
    push(16'h6002, 0);
    chk("pre_rst_valid", 32'(clause_valid_out), 32'h1);
    do_reset();
    chk("midrst_valid", 32'(clause_valid_out), 32'h0);
    chk("midrst_cur_eng", 32'(cur_eng), 32'h0);
    chk("midrst_all_loaded", 32'(all_loaded), 32'h0);
    chk("midrst_ready", 32'(node_in_ready), 32'h1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clause_dist_buffer.md
# clause_dist_buffer

Parametrised clause/dummy-pointer loader that distributes an incoming clause stream across `NUM_ENGINE` BCP engines, successor to the single-load L-buffer. Sits between the host/memory loader and the per-engine clause queues in the lookup top level. Adds per-engine FIFO buffering with valid/ready backpressure and two engine-advance modes: manual via `change_eng`, or automatic after a programmable clause quota.

## Interface
Parameters:
- `NUM_ENGINE`, 4: number of engines (≥1); `ENG_W = $clog2(NUM_ENGINE)` (min 1)
- `FIFO_DEPTH`, 4: clause FIFO entries per engine (power of two, ≥2)
- `QUOTA_W`, 8: width of auto-mode quota

Ports (single clock; reset is synchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `mode`  in  1  0 = manual advance, 1 = auto advance
- `quota`  in  QUOTA_W  clauses per engine in auto mode (0 treated as 1)
- `node_in`  in  node_t  clause node
- `node_in_valid`  in  1  clause offered
- `node_in_ready`  out  1  clause accepted when valid&ready
- `ptr_in`  in  ptr_t  dummy pointer for current engine
- `ptr_in_valid`  in  1  pointer write (always accepted)
- `change_eng`  in  1  manual advance request (ignored when `mode`=1)
- `clause_out`  out  [NUM_ENGINE] node_t  FIFO heads
- `clause_valid_out`  out  [NUM_ENGINE]  FIFO non-empty
- `clause_ready_in`  in  [NUM_ENGINE]  engine pops head
- `ptr_out`  out  [NUM_ENGINE] ptr_t  held pointer per engine
- `ptr_valid_out`  out  [NUM_ENGINE]  one-cycle write strobe
- `cur_eng`  out  ENG_W  engine currently being loaded
- `all_loaded`  out  1  sticky: advance has wrapped from last engine

## Operation
- Clause path: accepted node pushed into FIFO[`cur_eng`]; `node_in_ready` = !full[`cur_eng`], depends on state only, never on `node_in_valid`.
- Per-engine FIFO: pop when `clause_valid_out[i]`&`clause_ready_in[i]`; simultaneous push+pop on a full FIFO is not allowed (ready already low); on empty FIFO, push only (no bypass).
- Pointer path: `ptr_in_valid` writes `ptr_out[cur_eng]` and pulses `ptr_valid_out[cur_eng]` next cycle; other engines' pointers unchanged.
- Advance: `cur_eng` ← `cur_eng`+1, wrapping `NUM_ENGINE-1`→0; wrap sets `all_loaded`.
  - Manual: on `change_eng`=1.
  - Auto: per-engine counter `cnt` increments on each accepted node; when accept makes `cnt`==max(`quota`,1), advance and clear `cnt`.
- Simultaneous events: node/pointer accepted in same cycle as advance go to the old engine; advance takes effect for the following cycle. `change_eng` in auto mode ignored; `mode` change mid-load clears `cnt`.
- `NUM_ENGINE`=1: advance keeps `cur_eng`=0 and sets `all_loaded`.

## Timing
- Reset (`rst_n`=0 at edge): FIFOs emptied, `cur_eng`=0, `cnt`=0, `all_loaded`=0, `ptr_out`=0, `ptr_valid_out`=0, `clause_valid_out`=0, `node_in_ready`=1. Reset mid-load discards all buffered clauses.
- Clause latency: accepted at edge N → `clause_valid_out` high after edge N, visible in cycle N+1.
- Throughput: 1 clause/cycle while target FIFO not full.
- Pointer strobe: `ptr_in_valid` at edge N → `ptr_out`/`ptr_valid_out` valid in cycle N+1 for exactly one cycle.
- `cur_eng` updates at the edge of the advance event.

## Structure
- `node_t`, `ptr_t`, `NUM_ENGINE` default in the shared solver package; no local typedefs.
- One sub-module: `sync_fifo` (parametrised width/depth, push/pop/full/empty), instantiated `NUM_ENGINE` times via generate.
- Advance/quota logic and pointer registers in this module.

## Test plan
- Manual: NUM_ENGINE=4, push 3 nodes, `change_eng`, push 2 → FIFO0 holds 3, FIFO1 holds 2 in order, `cur_eng`=1.
- Auto: `mode`=1, `quota`=2, push 8 nodes back-to-back → 2 per engine, `all_loaded`=1 after the 8th, `cur_eng`=0.
- Backpressure: `clause_ready_in`=0, push 5 into engine 0 with FIFO_DEPTH=4 → `node_in_ready` low after 4, 5th accepted the cycle after one pop.
- Simultaneous: node + `ptr_in_valid` + `change_eng` in same cycle on engine 2 → node in FIFO2, `ptr_valid_out[2]` pulses, `cur_eng`=3.
- Quota 0: `mode`=1, `quota`=0 → advance after every node.
- Reset mid-load: 3 nodes buffered, `rst_n`=0 one cycle → all `clause_valid_out`=0, `cur_eng`=0, `all_loaded`=0.
